control_sequencer: RTL and testbench

Hardwired control unit that drives the bus-based datapath. It runs the fetch sequence (PC→MAR, PC+1, memory read, MDR→IR), decodes the IR, and issues the per-cycle register-select and ALU strobes for register-to-register ALU, MUL/DIV (HI/LO), unary NEG/NOT, NOP and HALT. It replaces the hand-sequenced control signals currently driven from the bench and sits beside the datapath, wired 1:1 to its control inputs.

---
 rtl/control_sequencer.sv | 165 ++++++++++++++++
 tb/tb_control_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit for the bus datapath
module control_sequencer #(
  parameter int REGISTERS    = 16,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [31:0]          IR,
  input  logic                 Mem_ready,
  input  logic                 Stop,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 RZin,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 PCin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 RYin,
  output logic                 HIin,
  output logic                 LOin,
  output logic [REGISTERS-1:0] Rin,
  output logic [REGISTERS-1:0] Rout,
  output logic [11:0]          Alu_op,
  output logic                 Run,
  output logic                 Illegal
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  typedef enum logic [3:0] {
    RESET_ST, FETCH0, FETCH1, FETCH2, DECODE, EX4, WB_LO, WB_HI, HALTED
  } state_t;
  state_t              state, state_nx;
  logic [CW-1:0]       wait_cnt;
  logic [4:0]          op;
  logic [3:0]          ra, rb, rc;
  logic [11:0]         alu_sel;
  logic                is_bin, is_md, is_un, is_nop, is_halt, timeout;
  logic [REGISTERS-1:0] one_a, one_b, one_c;
  logic                unused_ir;
  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign one_a     = {{(REGISTERS-1){1'b0}}, 1'b1} << ra;
  assign one_b     = {{(REGISTERS-1){1'b0}}, 1'b1} << rb;
  assign one_c     = {{(REGISTERS-1){1'b0}}, 1'b1} << rc;
  assign is_md     = (op == 5'd15) || (op == 5'd16);
  assign is_un     = (op == 5'd17) || (op == 5'd18);
  assign is_bin    = (alu_sel != '0) && !is_un;
  assign is_nop    = op == 5'd26;
  assign is_halt   = op == 5'd27;
  assign timeout   = wait_cnt == CW'(MEM_WAIT_MAX);
  assign Run       = (state != RESET_ST) && (state != HALTED);
  // opcode to one-hot ALU strobe; zero means no ALU operation
  always_comb begin
    case (op)
      5'd3:    alu_sel = 12'h001;
      5'd4:    alu_sel = 12'h002;
      5'd15:   alu_sel = 12'h004;
      5'd16:   alu_sel = 12'h008;
      5'd5:    alu_sel = 12'h010;
      5'd6:    alu_sel = 12'h020;
      5'd7:    alu_sel = 12'h040;
      5'd8:    alu_sel = 12'h080;
      5'd9:    alu_sel = 12'h100;
      5'd10:   alu_sel = 12'h200;
      5'd17:   alu_sel = 12'h400;
      5'd18:   alu_sel = 12'h800;
      default: alu_sel = 12'h000;
    endcase
  end
  // state register; reset drops straight into RESET_ST
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= RESET_ST;
    else          state <= state_nx;
  end
  // memory wait counter, live only while stalled in FETCH1
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) wait_cnt <= '0;
    else          wait_cnt <= (state == FETCH1 && !Mem_ready && !timeout) ? wait_cnt + 1'b1 : '0;
  end
  // next state and Moore strobes from state and IR
  always_comb begin
    state_nx = state;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    RZin     = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    RYin     = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    Alu_op   = '0;
    Illegal  = 1'b0;
    case (state)
      RESET_ST: state_nx = FETCH0;
      FETCH0: begin
        PCout    = 1'b1;
        MARin    = 1'b1;
        IncPC    = 1'b1;
        RZin     = 1'b1;
        state_nx = FETCH1;
      end
      FETCH1: begin
        Zlowout  = 1'b1;
        PCin     = 1'b1;
        Read     = 1'b1;
        MDRin    = 1'b1;
        Illegal  = timeout;
        state_nx = timeout ? FETCH0 : Mem_ready ? FETCH2 : FETCH1;
      end
      FETCH2: begin
        MDRout   = 1'b1;
        IRin     = 1'b1;
        state_nx = DECODE;
      end
      DECODE: begin
        if (is_bin) begin
          Rout     = one_b;
          RYin     = 1'b1;
          state_nx = EX4;
        end else if (is_un) begin
          Rout     = one_b;
          Alu_op   = alu_sel;
          RZin     = 1'b1;
          state_nx = WB_LO;
        end else begin
          Illegal  = !is_nop && !is_halt;
          state_nx = is_halt ? HALTED : FETCH0;
        end
      end
      EX4: begin
        Rout     = one_c;
        Alu_op   = alu_sel;
        RZin     = 1'b1;
        state_nx = WB_LO;
      end
      WB_LO: begin
        Zlowout  = 1'b1;
        LOin     = is_md;
        Rin      = is_md ? '0 : one_a;
        state_nx = is_md ? WB_HI : Stop ? HALTED : FETCH0;
      end
      WB_HI: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_nx = Stop ? HALTED : FETCH0;
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = RESET_ST;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed cycle-by-cycle check of the control sequencer
module tb_control_sequencer;
  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] IR = '0;
  logic        Mem_ready = 1'b1;
  logic        Stop = 1'b0;
  logic PCout, MARin, IncPC, RZin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, RYin, HIin, LOin, Run, Illegal;
  logic [15:0] Rin, Rout;
  logic [11:0] Alu_op;
  logic [59:0] obs;
  int          errors = 0;
  int          checks = 0;
  localparam logic [15:0] C_ZERO = 16'h0000;
  localparam logic [15:0] C_F0   = 16'hF002;
  localparam logic [15:0] C_F1   = 16'h0B82;
  localparam logic [15:0] C_TO   = 16'h0B83;
  localparam logic [15:0] C_F2   = 16'h0062;
  localparam logic [15:0] C_RY   = 16'h0012;
  localparam logic [15:0] C_RZ   = 16'h1002;
  localparam logic [15:0] C_WB   = 16'h0802;
  localparam logic [15:0] C_WLO  = 16'h0806;
  localparam logic [15:0] C_WHI  = 16'h040A;
  localparam logic [15:0] C_ILL  = 16'h0003;
  localparam logic [15:0] C_RUN  = 16'h0002;
  localparam logic [31:0] I_AND  = 32'h4A920000;
  localparam logic [31:0] I_MUL  = 32'h7A920000;
  localparam logic [31:0] I_NEG  = 32'h8A900000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_BAD  = 32'hF8000000;

  control_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .RYin(RYin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .Alu_op(Alu_op), .Run(Run), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  assign obs = {PCout, MARin, IncPC, RZin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout,
                IRin, RYin, HIin, LOin, Run, Illegal, Rin, Rout, Alu_op};

  task automatic chk(input string tag, input logic [15:0] c, input logic [15:0] ri,
                     input logic [15:0] ro, input logic [11:0] al);
    logic [59:0] e;
    e = {c, ri, ro, al};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic cyc(input string tag, input logic [15:0] c, input logic [15:0] ri,
                     input logic [15:0] ro, input logic [11:0] al);
    chk(tag, c, ri, ro, al);
    @(negedge Clock);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_f0"}, C_F0, 16'h0, 16'h0, 12'h0);
    cyc({tag, "_f1"}, C_F1, 16'h0, 16'h0, 12'h0);
    cyc({tag, "_f2"}, C_F2, 16'h0, 16'h0, 12'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge Clock);
    cyc("reset_hold", C_ZERO, 16'h0, 16'h0, 12'h0);
    chk("reset_state", C_ZERO, 16'h0, 16'h0, 12'h0);
    Reset_n = 1'b1;
    IR = I_AND;
    @(negedge Clock);
    fetch("and");
    cyc("and_t3", C_RY, 16'h0, 16'h0004, 12'h0);
    cyc("and_t4", C_RZ, 16'h0, 16'h0010, 12'h100);
    cyc("and_t5", C_WB, 16'h0020, 16'h0, 12'h0);
    IR = I_MUL;
    fetch("mul");
    cyc("mul_t3", C_RY, 16'h0, 16'h0004, 12'h0);
    cyc("mul_t4", C_RZ, 16'h0, 16'h0010, 12'h004);
    cyc("mul_t5", C_WLO, 16'h0, 16'h0, 12'h0);
    cyc("mul_t6", C_WHI, 16'h0, 16'h0, 12'h0);
    IR = I_NEG;
    fetch("neg");
    cyc("neg_t3", C_RZ, 16'h0, 16'h0004, 12'h400);
    cyc("neg_t4", C_WB, 16'h0020, 16'h0, 12'h0);
    IR = I_NOP;
    cyc("wait_f0", C_F0, 16'h0, 16'h0, 12'h0);
    Mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("wait_f1_low", C_F1, 16'h0, 16'h0, 12'h0);
    Mem_ready = 1'b1;
    cyc("wait_f1_ready", C_F1, 16'h0, 16'h0, 12'h0);
    cyc("wait_f2", C_F2, 16'h0, 16'h0, 12'h0);
    cyc("nop_t3", C_RUN, 16'h0, 16'h0, 12'h0);
    IR = I_AND;
    cyc("to_f0", C_F0, 16'h0, 16'h0, 12'h0);
    Mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("to_f1_low", C_F1, 16'h0, 16'h0, 12'h0);
    cyc("to_illegal", C_TO, 16'h0, 16'h0, 12'h0);
    Mem_ready = 1'b1;
    IR = I_BAD;
    fetch("bad");
    cyc("bad_t3", C_ILL, 16'h0, 16'h0, 12'h0);
    IR = I_NOP;
    Stop = 1'b1;
    fetch("nopstop");
    cyc("nopstop_t3", C_RUN, 16'h0, 16'h0, 12'h0);
    Stop = 1'b0;
    IR = I_AND;
    fetch("andstop");
    cyc("andstop_t3", C_RY, 16'h0, 16'h0004, 12'h0);
    cyc("andstop_t4", C_RZ, 16'h0, 16'h0010, 12'h100);
    Stop = 1'b1;
    cyc("andstop_t5", C_WB, 16'h0020, 16'h0, 12'h0);
    Stop = 1'b0;
    cyc("halted_a", C_ZERO, 16'h0, 16'h0, 12'h0);
    cyc("halted_b", C_ZERO, 16'h0, 16'h0, 12'h0);
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    IR = I_HALT;
    @(negedge Clock);
    fetch("halt");
    cyc("halt_t3", C_RUN, 16'h0, 16'h0, 12'h0);
    for (int i = 0; i < 3; i++) cyc("halt_stay", C_ZERO, 16'h0, 16'h0, 12'h0);
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    IR = I_AND;
    @(negedge Clock);
    fetch("rst");
    cyc("rst_t3", C_RY, 16'h0, 16'h0004, 12'h0);
    chk("rst_t4", C_RZ, 16'h0, 16'h0010, 12'h100);
    #1 Reset_n = 1'b0;
    #1 chk("rst_async", C_ZERO, 16'h0, 16'h0, 12'h0);
    @(negedge Clock);
    cyc("rst_hold", C_ZERO, 16'h0, 16'h0, 12'h0);
    Reset_n = 1'b1;
    cyc("rst_idle", C_ZERO, 16'h0, 16'h0, 12'h0);
    cyc("rst_restart", C_F0, 16'h0, 16'h0, 12'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
